// File: rtl/anim_pkg.sv
// Shared types and constants for the animation frame stepper.
// Holds FSM encodings and the speed-to-period mapping.
package anim_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam int unsigned PERIOD_BASE = 16;

  function automatic logic [3:0] period_of(
    input logic [3:0] speed
  );
    logic [4:0] p;
    p = 5'(PERIOD_BASE) - {1'b0, speed};
    return p[3:0];
  endfunction

endpackage

// File: rtl/anim_prescaler.sv
// Free-running base-tick prescaler for the frame stepper.
// Counts only while run is high; clr forces it back to zero.
module anim_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic run,
  input  logic clr,
  output logic tick
);

  logic [PRESC_W-1:0] cnt;

  // Tick marks the cycle whose edge wraps the counter to 0.
  assign tick = ena && run && !clr
             && (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/anim_step_ctrl.sv
// Animation frame step controller: STOP/RUN/PAUSE FSM.
// Optional ANIM_PINGPONG_EN makes the index bounce at both ends.
module anim_step_ctrl
  import anim_pkg::*;
#(
  parameter int FRAMES  = 8,
  parameter int PRESC_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] speed,
  input  logic       dir,
  input  logic       hold,
  input  logic       step_req,
  output logic [3:0] frame_idx,
  output logic       frame_stb,
  output logic [1:0] state_o
);

  localparam logic [3:0] IDX_MAX =
    4'(FRAMES - 1);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] period_q;
  logic [3:0] idx_nxt;
  logic       tick;
  logic       presc_clr;
  logic       presc_run;
  logic       load;
  logic       step_run;
  logic       step_man;
  logic       do_step;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (speed == '0):
        state_d = STOP;
      (speed != '0 && hold):
        state_d = PAUSE;
      (speed != '0 && !hold):
        state_d = RUN;
      default:
        state_d = STOP;
    endcase
  end

  assign presc_clr = (state_d == STOP);
  assign presc_run = (state_q == RUN);

  anim_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .run   (presc_run),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // A zero period means no count in flight, so RUN entry reloads.
  assign load = (state_q != RUN)
             && (state_d == RUN)
             && (period_q == '0);

  assign step_run = tick && (period_q == 4'd1);
  assign step_man = (state_q == STOP) && step_req;
  assign do_step  = ena && (step_run || step_man);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
    end else if (ena) begin
      if (state_d == STOP) begin
        period_q <= '0;
      end else if (load) begin
        period_q <= period_of(speed);
      end else if (tick) begin
        if (period_q == 4'd1) begin
          period_q <= period_of(speed);
        end else begin
          period_q <= period_q - 4'd1;
        end
      end
    end
  end

`ifdef ANIM_PINGPONG_EN
  logic bounce_q;
  logic bounce_nxt;
  logic eff_dir;

  assign eff_dir = dir ^ bounce_q;

  always_comb begin
    idx_nxt    = frame_idx;
    bounce_nxt = bounce_q;
    unique case (1'b1)
      (!eff_dir && frame_idx == IDX_MAX): begin
        idx_nxt    = frame_idx - 4'd1;
        bounce_nxt = !bounce_q;
      end
      (eff_dir && frame_idx == '0): begin
        idx_nxt    = 4'd1;
        bounce_nxt = !bounce_q;
      end
      (!eff_dir && frame_idx != IDX_MAX):
        idx_nxt = frame_idx + 4'd1;
      (eff_dir && frame_idx != '0):
        idx_nxt = frame_idx - 4'd1;
      default:
        idx_nxt = frame_idx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bounce_q <= 1'b0;
    end else if (do_step) begin
      bounce_q <= bounce_nxt;
    end
  end
`else
  always_comb begin
    idx_nxt = frame_idx;
    unique case (1'b1)
      (!dir && frame_idx == IDX_MAX):
        idx_nxt = '0;
      (dir && frame_idx == '0):
        idx_nxt = IDX_MAX;
      (!dir && frame_idx != IDX_MAX):
        idx_nxt = frame_idx + 4'd1;
      (dir && frame_idx != '0):
        idx_nxt = frame_idx - 4'd1;
      default:
        idx_nxt = frame_idx;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STOP;
      frame_idx <= '0;
      frame_stb <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      frame_stb <= do_step;
      if (do_step) begin
        frame_idx <= idx_nxt;
      end
    end else begin
      frame_stb <= 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_anim_step_ctrl.sv
// Directed bench for anim_step_ctrl (PRESC_W=2, FRAMES=8).
// Vector table plus hand sequences for multi-cycle timing.
module tb_anim_step_ctrl;

  localparam int S_STOP  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] speed = 4'd0;
  logic       dir = 1'b0;
  logic       hold = 1'b0;
  logic       step_req = 1'b0;
  logic [3:0] frame_idx;
  logic       frame_stb;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  anim_step_ctrl #(
    .FRAMES  (8),
    .PRESC_W (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .speed     (speed),
    .dir       (dir),
    .hold      (hold),
    .step_req  (step_req),
    .frame_idx (frame_idx),
    .frame_stb (frame_stb),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic [3:0] speed;
    logic       dir;
    logic       hold;
    logic       step;
    int         idx;
    int         stb;
    int         st;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] spd,
                          input logic d);
    rst_n    = 1'b0;
    ena      = 1'b1;
    speed    = spd;
    dir      = d;
    hold     = 1'b0;
    step_req = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic int exp_up(input int pos);
    int p;
`ifdef ANIM_PINGPONG_EN
    p = pos % 14;
    return (p <= 7) ? p : 14 - p;
`else
    p = pos % 8;
    return p;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int wrap7;
    int b1;
    int b2;
`ifdef ANIM_PINGPONG_EN
    wrap7 = 1;
    b1    = 1;
    b2    = 2;
`else
    wrap7 = 7;
    b1    = 7;
    b2    = 6;
`endif
    tv[0]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, S_STOP};
    tv[1]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1, 1, S_STOP};
    tv[2]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1, 0, S_STOP};
    tv[3]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 2, 1, S_STOP};
    tv[4]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2, 0, S_STOP};
    tv[5]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1, 1, S_STOP};
    tv[6]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 0, 1, S_STOP};
    tv[7]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b1, wrap7, 1, S_STOP};
    tv[8]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 0, 1, S_STOP};
    tv[9]  = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 0, 0, S_RUN};
    tv[10] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 0, 0, S_RUN};
    tv[11] = '{1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 0, 0, S_PAUSE};
    tv[12] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, S_STOP};
    tv[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 0, S_STOP};
    tv[14] = '{1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 0, 0, S_STOP};
    tv[15] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 0, 0, S_STOP};
    tv[16] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1, 1, S_STOP};

    // Asynchronous reset, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_idx", frame_idx, 0);
    chk("rst_stb", frame_stb, 0);
    chk("rst_state", state_o, S_STOP);
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      ena      = tv[i].ena;
      speed    = tv[i].speed;
      dir      = tv[i].dir;
      hold     = tv[i].hold;
      step_req = tv[i].step;
      cyc();
      chk($sformatf("tv%0d_idx", i), frame_idx, tv[i].idx);
      chk($sformatf("tv%0d_stb", i), frame_stb, tv[i].stb);
      chk($sformatf("tv%0d_st", i), state_o, tv[i].st);
    end
    step_req = 1'b0;
    ena      = 1'b1;

    // Fastest rate: one step per base tick.
    do_reset(4'd15, 1'b0);
    for (int k = 0; k <= 36; k++) begin
      cyc();
      chk($sformatf("run15_stb_k%0d", k), frame_stb,
          (k > 0 && k % 4 == 0) ? 1 : 0);
      chk($sformatf("run15_idx_k%0d", k), frame_idx,
          exp_up(k / 4));
      chk($sformatf("run15_st_k%0d", k), state_o, S_RUN);
    end
    ena = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("ena_idx", frame_idx, exp_up(9));
      chk("ena_stb", frame_stb, 0);
      chk("ena_st", state_o, S_RUN);
    end
    ena = 1'b1;

    // Slow rate, decrementing from frame 0.
    do_reset(4'd3, 1'b1);
    for (int k = 0; k <= 104; k++) begin
      cyc();
      chk($sformatf("run3_stb_k%0d", k), frame_stb,
          (k == 52 || k == 104) ? 1 : 0);
      chk($sformatf("run3_idx_k%0d", k), frame_idx,
          (k < 52) ? 0 : (k < 104) ? b1 : b2);
    end

    // Hold for 10 cycles in the middle of a period.
    do_reset(4'd15, 1'b0);
    for (int k = 0; k <= 6; k++) cyc();
    hold = 1'b1;
    for (int k = 7; k <= 16; k++) begin
      cyc();
      chk($sformatf("hold_st_k%0d", k), state_o, S_PAUSE);
      chk($sformatf("hold_stb_k%0d", k), frame_stb, 0);
    end
    hold = 1'b0;
    cyc();
    chk("resume_st", state_o, S_RUN);
    chk("resume_stb17", frame_stb, 0);
    chk("resume_idx17", frame_idx, 1);
    cyc();
    chk("resume_stb18", frame_stb, 1);
    chk("resume_idx18", frame_idx, 2);

    // Reset pulse mid-period discards progress.
    do_reset(4'd15, 1'b0);
    for (int k = 0; k <= 22; k++) cyc();
    chk("pre_rst_idx", frame_idx, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_idx", frame_idx, 0);
    chk("mid_rst_st", state_o, S_STOP);
    chk("mid_rst_stb", frame_stb, 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      cyc();
      chk($sformatf("post_rst_stb_k%0d", k), frame_stb,
          (k == 4) ? 1 : 0);
      chk($sformatf("post_rst_idx_k%0d", k), frame_idx,
          (k == 4) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/anim_step_ctrl.md
ANIM_STEP_CTRL -- requirements
Module: anim_step_ctrl

Interface
REQ-001 Parameter FRAMES, default 8, number of animation frames (2..16).
REQ-002 Parameter PRESC_W, default 4, prescaler width; base tick every 2^PRESC_W clk cycles.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  design enable; low freezes all state except reset.
REQ-006 speed  input  4  rate select; 0 = stopped, 1..15 = step every (16-speed) base ticks.
REQ-007 dir  input  1  0 = increment frame index, 1 = decrement.
REQ-008 hold  input  1  pause request; level-sensitive.
REQ-009 step_req  input  1  single-cycle single-step pulse, honoured only in STOP.
REQ-010 frame_idx  output  4  current frame, registered, range 0..FRAMES-1.
REQ-011 frame_stb  output  1  one-cycle pulse in the cycle frame_idx takes a new value.
REQ-012 state_o  output  2  current FSM state encoding, for debug.

Function
REQ-013 FSM states: STOP (speed==0), RUN (speed!=0, hold low), PAUSE (speed!=0, hold high).
REQ-014 Transitions evaluated every enabled cycle; priority: speed==0 -> STOP, else hold -> PAUSE, else RUN.
REQ-015 Prescaler: PRESC_W-bit free-running counter in RUN only; base tick when it wraps to 0.
REQ-016 Period counter: loaded with (16-speed) on entry to RUN and after each step; decremented on base tick; step when it reaches 0 on a tick.
REQ-017 Speed change while in RUN takes effect at the next period reload, not mid-period.
REQ-018 PAUSE holds prescaler, period counter and frame_idx; returning to RUN resumes the remaining count without reload.
REQ-019 STOP clears prescaler and period counter; step_req in STOP advances frame_idx one step in the next cycle with frame_stb.
REQ-020 step_req outside STOP is ignored; no queued steps.
REQ-021 Step with dir=0: frame_idx = FRAMES-1 wraps to 0; dir=1: 0 wraps to FRAMES-1.
REQ-022 dir sampled at the step cycle; a dir change never itself produces a step.
REQ-023 ena low: no counter, FSM or output changes; frame_stb held 0.
REQ-024 Latency: frame_stb asserts exactly (16-speed)*2^PRESC_W cycles after RUN entry at fixed speed.

Reset
REQ-025 rst_n low asynchronously forces frame_idx=0, frame_stb=0, state STOP, all counters 0.
REQ-026 Reset mid-period discards progress; first step after release requires a full period.

Configuration
REQ-027 Macro ANIM_PINGPONG_EN defined: index bounces at ends (0 and FRAMES-1) by toggling an internal bounce flag; effective direction = dir XOR bounce; bounce cleared by reset.
REQ-028 Macro ANIM_PINGPONG_EN undefined: wrap behaviour per REQ-021, no bounce flag logic.

Structure
REQ-029 Shared package anim_pkg holds the state enum (STOP/RUN/PAUSE encodings) and the speed-to-period constant 16.
REQ-030 One sub-module anim_prescaler (counter plus tick pulse, with run/clear inputs) is natural; FSM and frame logic stay in anim_step_ctrl.

Verification (PRESC_W=2, FRAMES=8)
REQ-031 Reset release, speed=15, dir=0 -> frame_stb every 4 cycles, frame_idx 0,1,..,7,0.
REQ-032 speed=3, dir=1 from frame 0 -> first step after 52 cycles, frame_idx 7, then 6.
REQ-033 RUN speed=15, hold high 10 cycles mid-period -> step delayed exactly 10 cycles, no frame_stb during PAUSE.
REQ-034 speed=0, step_req pulse twice -> frame_idx 0->1->2, one frame_stb each; step_req with speed=5 -> no change.
REQ-035 rst_n low for 1 cycle mid-period at frame 5 -> frame_idx 0 immediately, next step after full period.
REQ-036 ANIM_PINGPONG_EN defined, speed=15, dir=0 -> frame_idx 0..7,6,5..0,1.
